// File: rtl/spi_flash_emu_responder_if.sv
// spi_flash_emu_responder_if: SPI pins plus byte-wide memory read port of the flash emulator.
//   slave  (device): samples spi_sck/spi_csb/spi_sd0, mem_rvalid/mem_rdata; drives spi_sd1/spi_sd1_oe, mem_req/mem_addr
//   master (host/memory side): the opposite directions
interface spi_flash_emu_responder_if #(
    parameter int ADDR_W = 24
);
    logic              spi_sck;
    logic              spi_csb;
    logic              spi_sd0;
    logic              spi_sd1;
    logic              spi_sd1_oe;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [7:0]        mem_rdata;
    modport slave (
        input  spi_sck, spi_csb, spi_sd0, mem_rvalid, mem_rdata,
        output spi_sd1, spi_sd1_oe, mem_req, mem_addr
    );
    modport master (
        output spi_sck, spi_csb, spi_sd0, mem_rvalid, mem_rdata,
        input  spi_sd1, spi_sd1_oe, mem_req, mem_addr
    );
endinterface

// File: rtl/spi_flash_emu_responder.sv
// spi_flash_emu_responder: SPI mode-0 flash device model answering READ (03), RDID (9F), RDSR (05) from a byte memory port.
//   clk_i, rst_ni : system clock (>=16x sck), synchronous active-low reset
//   bus (slave)   : SPI sck/csb/sd0 in, sd1/sd1_oe out; mem_req/mem_addr out, mem_rvalid/mem_rdata in
//   busy_o        : transaction in progress
//   opcode_o      : last complete opcode
//   underrun_o    : sticky, a READ data byte was not available at its first falling edge
module spi_flash_emu_responder #(
    parameter int          ADDR_W      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    spi_flash_emu_responder_if.slave   bus,
    output logic                       busy_o,
    output logic [7:0]                 opcode_o,
    output logic                       underrun_o
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_RDID, S_RDSR, S_IGNORE} state_t;
    state_t              r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sck_sync, r_csb_sync, r_sd0_sync;
    logic                r_sck_d, r_csb_d;
    logic [4:0]          r_bit_cnt;
    logic [22:0]         r_sh;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_req, r_pend, r_buf_vld, r_sd1, r_oe, r_underrun;
    logic [7:0]          r_buf, r_out, r_opcode;
    logic [2:0]          r_out_cnt;
    logic [1:0]          r_id_idx;
    logic                w_sck, w_csb, w_sd0, w_rise, w_fall, w_csb_fall, w_csb_rise;
    logic                w_cmd_done, w_last_addr, w_stream, w_first, w_first_data, w_issue, w_rv, w_under;
    logic [23:0]         w_shin;
    logic [7:0]          w_byte, w_id;
    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_csb      = r_csb_sync[SYNC_STAGES-1];
    assign w_sd0      = r_sd0_sync[SYNC_STAGES-1];
    // gating sck edges with csb also makes a simultaneous csb rise win
    assign w_rise     = w_sck & ~r_sck_d & ~w_csb;
    assign w_fall     = ~w_sck & r_sck_d & ~w_csb;
    assign w_csb_fall = ~w_csb & r_csb_d;
    assign w_csb_rise = w_csb & ~r_csb_d;
    assign w_shin     = {r_sh, w_sd0};
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sck_sync <= '0;
            r_csb_sync <= '1;
            r_sd0_sync <= '0;
            r_sck_d    <= 1'b0;
            r_csb_d    <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], bus.spi_csb};
            r_sd0_sync <= {r_sd0_sync[SYNC_STAGES-2:0], bus.spi_sd0};
            r_sck_d    <= w_sck;
            r_csb_d    <= w_csb;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE)
            w_next = w_csb_fall ? S_CMD : S_IDLE;
        else if (w_csb_rise)
            w_next = S_IDLE;
        else if (w_cmd_done)
            w_next = (w_shin[7:0] == 8'h03) ? S_ADDR :
                     (w_shin[7:0] == 8'h9F) ? S_RDID :
                     (w_shin[7:0] == 8'h05) ? S_RDSR : S_IGNORE;
        else if (w_last_addr)
            w_next = S_DATA;
    end
    always_comb begin
        w_cmd_done   = w_rise && r_state == S_CMD && r_bit_cnt == 5'd7;
        w_last_addr  = w_rise && r_state == S_ADDR && r_bit_cnt == 5'd23;
        w_stream     = r_state == S_DATA || r_state == S_RDID || r_state == S_RDSR;
        w_first      = w_fall && w_stream && r_out_cnt == 3'd0;
        w_first_data = w_first && r_state == S_DATA;
        // prefetch: byte n+1 is requested as the MSB of byte n goes out
        w_issue      = w_last_addr || w_first_data;
        w_rv         = bus.mem_rvalid && r_pend;
        w_under      = w_first_data && !r_buf_vld && !w_rv;
        w_id         = (r_id_idx == 2'd0) ? JEDEC_ID[23:16] : (r_id_idx == 2'd1) ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
        w_byte       = (r_state == S_DATA) ? (r_buf_vld ? r_buf : w_rv ? bus.mem_rdata : 8'hFF) :
                       (r_state == S_RDID) ? w_id : 8'h00;
        busy_o       = r_state != S_IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_bit_cnt <= '0;
            r_sh      <= '0;
            r_addr    <= '0;
            r_req     <= 1'b0;
            r_pend    <= 1'b0;
            r_buf_vld <= 1'b0;
            r_buf     <= '0;
            r_out     <= '0;
            r_out_cnt <= '0;
            r_id_idx  <= '0;
            r_sd1     <= 1'b0;
            r_oe      <= 1'b0;
        end else if (r_state == S_IDLE || w_csb_rise) begin
            r_bit_cnt <= '0;
            r_out_cnt <= '0;
            r_id_idx  <= '0;
            r_req     <= 1'b0;
            r_pend    <= 1'b0;
            r_buf_vld <= 1'b0;
            r_sd1     <= 1'b0;
            r_oe      <= 1'b0;
        end else begin
            r_req  <= w_issue;
            r_pend <= w_issue || (r_pend && !bus.mem_rvalid);
            if (w_rise) begin
                r_sh      <= w_shin[22:0];
                r_bit_cnt <= (w_cmd_done || w_last_addr) ? 5'd0 : r_bit_cnt + 5'd1;
            end
            if (w_last_addr)  r_addr <= w_shin[ADDR_W-1:0];
            if (w_first_data) r_addr <= r_addr + ADDR_W'(1);
            // rdata consumed straight through on an empty-buffer first fall is not also buffered
            if (w_rv && !(w_first_data && !r_buf_vld)) r_buf <= bus.mem_rdata;
            r_buf_vld <= (r_buf_vld && !w_first_data) || (w_rv && !(w_first_data && !r_buf_vld));
            if (w_fall && w_stream) begin
                r_oe      <= 1'b1;
                r_sd1     <= w_first ? w_byte[7] : r_out[7];
                r_out     <= w_first ? {w_byte[6:0], 1'b0} : {r_out[6:0], 1'b0};
                r_out_cnt <= r_out_cnt + 3'd1;
            end
            if (w_first && r_state == S_RDID) r_id_idx <= (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_opcode   <= 8'h00;
            r_underrun <= 1'b0;
        end else begin
            if (w_cmd_done) r_opcode <= w_shin[7:0];
            if (w_under)    r_underrun <= 1'b1;
        end
    end
    assign opcode_o       = r_opcode;
    assign underrun_o     = r_underrun;
    assign bus.spi_sd1    = r_sd1;
    assign bus.spi_sd1_oe = r_oe;
    assign bus.mem_req    = r_req;
    assign bus.mem_addr   = r_addr;
endmodule

// File: tb/tb_spi_flash_emu_responder.sv
// tb_spi_flash_emu_responder: directed SPI host + delayed memory model with expected-byte scoreboard.
`timescale 1ns/1ps
module tb_spi_flash_emu_responder;
    logic clk = 1'b0;
    logic rst_n, sck, sd0, csb0, csb1, sel;
    logic sd1_s, oe_s, m0_rv, m1_rv;
    logic [7:0] m0_rd, m1_rd;
    logic busy0, busy1, und0, und1;
    logic [7:0] op0, op1;
    int cyc = 0, dly = 2, errors = 0, checks = 0, nreq0 = 0, nreq1 = 0;
    logic [23:0] exp_a0 = '0;
    logic [11:0] exp_a1 = '0;
    logic [7:0] sb[$];
    int q0_due[$], q1_due[$];
    logic [23:0] q0_a[$], q1_a[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    spi_flash_emu_responder_if #(.ADDR_W(24)) if0 ();
    spi_flash_emu_responder_if #(.ADDR_W(12)) if1 ();
    assign if0.spi_sck = sck;
    assign if0.spi_csb = csb0;
    assign if0.spi_sd0 = sd0;
    assign if0.mem_rvalid = m0_rv;
    assign if0.mem_rdata = m0_rd;
    assign if1.spi_sck = sck;
    assign if1.spi_csb = csb1;
    assign if1.spi_sd0 = sd0;
    assign if1.mem_rvalid = m1_rv;
    assign if1.mem_rdata = m1_rd;
    assign sd1_s = sel ? if1.spi_sd1 : if0.spi_sd1;
    assign oe_s  = sel ? if1.spi_sd1_oe : if0.spi_sd1_oe;
    spi_flash_emu_responder #(.ADDR_W(24)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0), .busy_o(busy0), .opcode_o(op0), .underrun_o(und0));
    spi_flash_emu_responder #(.ADDR_W(12)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1), .busy_o(busy1), .opcode_o(op1), .underrun_o(und1));
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin : mem0
        m0_rv = 1'b0;
        m0_rd = '0;
        forever begin
            @(negedge clk);
            m0_rv = 1'b0;
            if (q0_due.size() > 0 && q0_due[0] <= cyc) begin
                m0_rv = 1'b1;
                m0_rd = mem_byte(q0_a[0]);
                void'(q0_due.pop_front());
                void'(q0_a.pop_front());
            end
            if (if0.mem_req) begin
                nreq0++;
                check("req_addr0", if0.mem_addr, exp_a0);
                exp_a0 = exp_a0 + 24'd1;
                q0_a.push_back(if0.mem_addr);
                q0_due.push_back(cyc + dly);
            end
        end
    end
    initial begin : mem1
        m1_rv = 1'b0;
        m1_rd = '0;
        forever begin
            @(negedge clk);
            m1_rv = 1'b0;
            if (q1_due.size() > 0 && q1_due[0] <= cyc) begin
                m1_rv = 1'b1;
                m1_rd = mem_byte(q1_a[0]);
                void'(q1_due.pop_front());
                void'(q1_a.pop_front());
            end
            if (if1.mem_req) begin
                nreq1++;
                check("req_addr1", if1.mem_addr, exp_a1);
                exp_a1 = exp_a1 + 12'd1;
                q1_a.push_back({12'h000, if1.mem_addr});
                q1_due.push_back(cyc + dly);
            end
        end
    end
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic set_cs(input logic v);
        if (sel) csb1 = v;
        else csb0 = v;
    endtask
    task automatic spi_bit(input logic b, output logic r, output logic oe);
        sd0 = b;
        wait_clk(8);
        r = sd1_s;
        oe = oe_s;
        sck = 1'b1;
        wait_clk(8);
        sck = 1'b0;
    endtask
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output int oe_cnt);
        logic o;
        oe_cnt = 0;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], rx[i], o);
            oe_cnt += int'(o);
        end
    endtask
    task automatic send(input logic [7:0] tx);
        logic [7:0] r;
        int n;
        spi_byte(tx, r, n);
    endtask
    task automatic rx_check(input string tag, input int nbytes);
        logic [7:0] r;
        int n;
        for (int i = 0; i < nbytes; i++) begin
            spi_byte(8'h00, r, n);
            check(tag, r, sb.pop_front());
            check({tag, "_oe"}, n, 8);
        end
    endtask
    task automatic end_txn();
        wait_clk(8);
        set_cs(1'b1);
        wait_clk(40);
    endtask
    task automatic check_reset(input string tag);
        check({tag, "_sd1"}, if0.spi_sd1, 0);
        check({tag, "_oe"}, if0.spi_sd1_oe, 0);
        check({tag, "_req"}, if0.mem_req, 0);
        check({tag, "_addr"}, if0.mem_addr, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_opcode"}, op0, 0);
        check({tag, "_underrun"}, und0, 0);
    endtask
    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        int n0, n;
        logic [7:0] r;
        logic b, o;
        sck = 0; sd0 = 0; csb0 = 1; csb1 = 1; sel = 0; rst_n = 0;
        wait_clk(4);
        check_reset("reset");
        rst_n = 1;
        wait_clk(4);
        // READ 0x000100, four bytes
        exp_a0 = 24'h000100;
        n0 = nreq0;
        set_cs(1'b0);
        wait_clk(8);
        send(8'h03); send(8'h00); send(8'h01); send(8'h00);
        check("read_busy", busy0, 1);
        for (int i = 0; i < 4; i++) sb.push_back(mem_byte(24'h000100 + 24'(i)));
        rx_check("read_byte", 4);
        end_txn();
        check("read_nreq", (nreq0 - n0) >= 4, 1);
        check("read_underrun", und0, 0);
        check("read_opcode", op0, 8'h03);
        check("read_idle_busy", busy0, 0);
        check("read_idle_oe", if0.spi_sd1_oe, 0);
        // RDID, six bytes, no memory traffic
        n0 = nreq0;
        set_cs(1'b0);
        wait_clk(8);
        send(8'h9F);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(8'hEF); sb.push_back(8'h40); sb.push_back(8'h18);
        end
        rx_check("rdid_byte", 6);
        end_txn();
        check("rdid_nreq", nreq0 - n0, 0);
        check("rdid_opcode", op0, 8'h9F);
        // 12-bit address space wraps 0xFFF -> 0x000
        sel = 1;
        exp_a1 = 12'hFFF;
        n0 = nreq1;
        set_cs(1'b0);
        wait_clk(8);
        send(8'h03); send(8'h00); send(8'h0F); send(8'hFF);
        sb.push_back(mem_byte(24'h000FFF));
        sb.push_back(mem_byte(24'h000000));
        rx_check("wrap_byte", 2);
        end_txn();
        check("wrap_nreq", (nreq1 - n0) >= 2, 1);
        check("wrap_underrun", und1, 0);
        sel = 0;
        // late memory: first byte underruns
        dly = 20;
        exp_a0 = 24'h000200;
        set_cs(1'b0);
        wait_clk(8);
        send(8'h03); send(8'h00); send(8'h02); send(8'h00);
        sb.push_back(8'hFF);
        rx_check("late_byte", 1);
        end_txn();
        check("late_underrun", und0, 1);
        dly = 2;
        wait_clk(40);
        // unknown opcode: silent but busy until csb high
        n0 = nreq0;
        set_cs(1'b0);
        wait_clk(8);
        send(8'hAB);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'h00, r, n);
            check("ign_oe", n, 0);
            check("ign_sd1", r, 0);
        end
        check("ign_busy", busy0, 1);
        check("ign_opcode", op0, 8'hAB);
        end_txn();
        check("ign_idle", busy0, 0);
        check("ign_nreq", nreq0 - n0, 0);
        // abort after 3 address bits, then RDSR
        n0 = nreq0;
        set_cs(1'b0);
        wait_clk(8);
        send(8'h03);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b, o);
        end_txn();
        check("abort_busy", busy0, 0);
        set_cs(1'b0);
        wait_clk(8);
        send(8'h05);
        sb.push_back(8'h00); sb.push_back(8'h00);
        rx_check("rdsr_byte", 2);
        end_txn();
        check("rdsr_nreq", nreq0 - n0, 0);
        check("rdsr_opcode", op0, 8'h05);
        check("sticky_underrun", und0, 1);
        // reset in the middle of a READ data byte
        exp_a0 = 24'h000100;
        set_cs(1'b0);
        wait_clk(8);
        send(8'h03); send(8'h00); send(8'h01); send(8'h00);
        sb.push_back(8'h11);
        rx_check("mid_byte", 1);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b, o);
        rst_n = 0;
        wait_clk(2);
        check_reset("midrst");
        csb0 = 1;
        wait_clk(4);
        rst_n = 1;
        wait_clk(8);
        check("post_rst_busy", busy0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
